// File: rtl/gate_sweep_checker_if.sv
// Stimulus/response bundle between gate_sweep_checker and the gate it exercises.
// master: bench/gate side (start, op, f); slave: checker side (x, y and status).
interface gate_sweep_checker_if;
  logic       start;
  logic [2:0] op;
  logic       f;
  logic       x;
  logic       y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] result;
  logic [2:0] err_count;

  modport master (
    output start, op, f,
    input  x, y, busy, done, pass, result, err_count
  );

  modport slave (
    input  start, op, f,
    output x, y, busy, done, pass, result, err_count
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// Sweeps a two-input gate through all four input vectors and checks f against the op truth table.
// Optional feature: define SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module gate_sweep_checker #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  gate_sweep_checker_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned VEC_W = 2;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned ERR_W = 3;
  localparam int unsigned RES_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               pass_q, pass_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               expected_c;
  logic               mismatch_c;

  // Reference value of the gate under test for the vector currently applied.
  always_comb begin
    expected_c = 1'b0;
    case (op_q)
      3'd0:    expected_c =   vec_q[1] & vec_q[0];
      3'd1:    expected_c =   vec_q[1] | vec_q[0];
      3'd2:    expected_c = ~(vec_q[1] & vec_q[0]);
      3'd3:    expected_c = ~(vec_q[1] | vec_q[0]);
      3'd4:    expected_c =   vec_q[1] ^ vec_q[0];
      3'd5:    expected_c = ~(vec_q[1] ^ vec_q[0]);
      3'd6:    expected_c = ~vec_q[1];
      default: expected_c =  vec_q[1];
    endcase
  end

  assign mismatch_c = (bus.f != expected_c);

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    pass_d   = pass_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          vec_d    = '0;
          cnt_d    = '0;
          result_d = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          state_d  = SETTLE;
        end
      end

      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        result_d[vec_q] = bus.f;
        if (mismatch_c) begin
          err_d = err_q + ERR_W'(1);
        end
`ifdef SWEEP_STOP_ON_FAIL_EN
        if (mismatch_c || (vec_q == VEC_W'(3))) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = '0;
          state_d = SETTLE;
        end
`else
        if (vec_q == VEC_W'(3)) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = '0;
          state_d = SETTLE;
        end
`endif
      end

      DONE: begin
        pass_d  = (err_q == '0);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      vec_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // x/y come straight from the vector register, so they hold after the sweep.
  assign bus.x         = vec_q[1];
  assign bus.y         = vec_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.result    = result_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: a table-driven gate model feeds f, a truth-table reference predicts results.
module tb_gate_sweep_checker;

  localparam int unsigned H         = 4;
  localparam int          SWEEP_LEN = 4 * (H + 1) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_sweep_checker_if bus ();

  gate_sweep_checker #(.HOLD_CYCLES(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Gate under test: f looked up from a table indexed by the applied {x,y}.
  logic [3:0] f_table = 4'b0000;
  assign bus.f = f_table[{bus.x, bus.y}];

  int n_cmp = 0;
  int n_bad = 0;

  int         obs_done_cyc, obs_done2_cyc, obs_done_n;
  logic [3:0] obs_result;
  logic [2:0] obs_err;
  logic       obs_pass;
  logic [1:0] obs_xy_hold;
  logic [11:0] obs_rst_snap;
  logic       obs_busy [0:63];
  logic [1:0] obs_xy   [0:63];

  logic [3:0] m_result;
  int         m_err;
  logic       m_pass;
  int         m_done_cyc;
  logic [1:0] m_last_xy;

  // Expected f for vectors 3..0 (bit v is the output for {x,y} = v).
  function automatic logic [3:0] truth(input logic [2:0] o);
    case (o)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1110;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      3'd6:    return 4'b0011;
      default: return 4'b1100;
    endcase
  endfunction

  task automatic model(input logic [2:0] o, input logic [3:0] ftab);
    logic [3:0] diff;
    logic [3:0] mask;
    int nvec;
    diff     = ftab ^ truth(o);
    nvec     = 4;
    m_err    = 0;
    for (int v = 0; v < 4; v++) if (diff[v]) m_err++;
    m_result = ftab;
`ifdef SWEEP_STOP_ON_FAIL_EN
    begin
      bit found;
      found = 1'b0;
      for (int v = 0; v < 4; v++) begin
        if (diff[v] && !found) begin
          found = 1'b1;
          nvec  = v + 1;
        end
      end
      if (found) m_err = 1;
      mask     = 4'((32'd1 << nvec) - 32'd1);
      m_result = ftab & mask;
    end
`else
    mask = 4'b1111;
    m_result = ftab & mask;
`endif
    m_pass     = (m_err == 0);
    m_done_cyc = nvec * int'(H + 1) + 1;
    m_last_xy  = 2'(nvec - 1);
  endtask

  // Counts cycles whose busy/x/y differ from the expected vector schedule up to done.
  function automatic int trace_dev(input int done_c);
    int dev;
    dev = 0;
    for (int c = 1; c <= done_c && c < 64; c++) begin
      if (c < done_c) begin
        if (obs_busy[c] !== 1'b1) dev++;
        if (obs_xy[c] !== 2'((c - 1) / int'(H + 1))) dev++;
      end else if (obs_busy[c] !== 1'b0) dev++;
    end
    return dev;
  endfunction

  task automatic do_sweep(input logic [2:0] op_i, input logic [3:0] ftab, input int limit,
                          input int release_at, input int pulse_at, input int reset_at);
    f_table       = ftab;
    obs_done_cyc  = 0;
    obs_done2_cyc = 0;
    obs_done_n    = 0;
    obs_result    = 'x;
    obs_err       = 'x;
    obs_pass      = 1'bx;
    obs_xy_hold   = 'x;
    obs_rst_snap  = 'x;
    for (int i = 0; i < 64; i++) begin
      obs_busy[i] = 1'bx;
      obs_xy[i]   = 'x;
    end
    @(negedge clk);
    bus.op    = op_i;
    bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c < 64) begin
        obs_busy[c] = bus.busy;
        obs_xy[c]   = {bus.x, bus.y};
      end
      if (bus.done === 1'b1) begin
        obs_done_n++;
        if (obs_done_n == 1) begin
          obs_done_cyc = c;
          obs_result   = bus.result;
          obs_err      = bus.err_count;
        end else if (obs_done_n == 2) begin
          obs_done2_cyc = c;
        end
      end
      if (obs_done_n >= 1 && c == obs_done_cyc + 1) begin
        obs_pass    = bus.pass;
        obs_xy_hold = {bus.x, bus.y};
      end
      if (c == release_at) bus.start = 1'b0;
      if (pulse_at > 0 && c == pulse_at) bus.start = 1'b1;
      if (pulse_at > 0 && c == pulse_at + 1) bus.start = 1'b0;
      if (reset_at > 0 && c == reset_at) begin
        rst_n = 1'b0;
        #1;
        obs_rst_snap = {bus.x, bus.y, bus.busy, bus.done, bus.pass, bus.result, bus.err_count};
      end
      if (reset_at > 0 && c == reset_at + 1) rst_n = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass: got %b want 0", bus.pass); end
    n_cmp++; if ({bus.x, bus.y} !== 2'b00) begin n_bad++; $display("FAIL reset_xy: got %b want 00", {bus.x, bus.y}); end
    n_cmp++; if (bus.result !== 4'b0000) begin n_bad++; $display("FAIL reset_result: got %b want 0000", bus.result); end
    n_cmp++; if (bus.err_count !== 3'd0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", bus.err_count); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ideal_gates;
    logic [2:0] ops  [3] = '{3'd0, 3'd3, 3'd5};
    logic [3:0] want [3] = '{4'b1000, 4'b0001, 4'b1001};
    for (int i = 0; i < 3; i++) begin
      do_sweep(ops[i], truth(ops[i]), SWEEP_LEN + 2, 1, 0, 0);
      n_cmp++; if (obs_done_cyc !== SWEEP_LEN) begin n_bad++; $display("FAIL ideal_done_cycle op%0d: got %0d want %0d", ops[i], obs_done_cyc, SWEEP_LEN); end
      n_cmp++; if (obs_result !== want[i]) begin n_bad++; $display("FAIL ideal_result op%0d: got %b want %b", ops[i], obs_result, want[i]); end
      n_cmp++; if (obs_err !== 3'd0) begin n_bad++; $display("FAIL ideal_err op%0d: got %0d want 0", ops[i], obs_err); end
      n_cmp++; if (obs_pass !== 1'b1) begin n_bad++; $display("FAIL ideal_pass op%0d: got %b want 1", ops[i], obs_pass); end
      n_cmp++; if (trace_dev(SWEEP_LEN) != 0) begin n_bad++; $display("FAIL ideal_xy_trace op%0d: got %0d bad cycles want 0", ops[i], trace_dev(SWEEP_LEN)); end
    end
  endtask

  task automatic test_stuck;
    logic [3:0] tabs [2] = '{4'b1111, 4'b0000};
    for (int i = 0; i < 2; i++) begin
      model(3'd0, tabs[i]);
      do_sweep(3'd0, tabs[i], SWEEP_LEN + 2, 1, 0, 0);
      n_cmp++; if (obs_result !== m_result) begin n_bad++; $display("FAIL stuck_result tab%b: got %b want %b", tabs[i], obs_result, m_result); end
      n_cmp++; if (obs_err !== 3'(m_err)) begin n_bad++; $display("FAIL stuck_err tab%b: got %0d want %0d", tabs[i], obs_err, m_err); end
      n_cmp++; if (obs_pass !== 1'b0) begin n_bad++; $display("FAIL stuck_pass tab%b: got %b want 0", tabs[i], obs_pass); end
      n_cmp++; if (obs_done_cyc !== m_done_cyc) begin n_bad++; $display("FAIL stuck_done_cycle tab%b: got %0d want %0d", tabs[i], obs_done_cyc, m_done_cyc); end
    end
  endtask

  task automatic test_start_ignored;
    do_sweep(3'd4, truth(3'd4), SWEEP_LEN + 9, 1, 5, 0);
    n_cmp++; if (obs_done_n !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", obs_done_n); end
    n_cmp++; if (obs_done_cyc !== SWEEP_LEN) begin n_bad++; $display("FAIL ignore_done_cycle: got %0d want %0d", obs_done_cyc, SWEEP_LEN); end
    n_cmp++; if (obs_result !== 4'b0110) begin n_bad++; $display("FAIL ignore_result: got %b want 0110", obs_result); end
  endtask

  task automatic test_reset_abort;
    do_sweep(3'd0, truth(3'd0), 30, 1, 0, 8);
    n_cmp++; if (obs_rst_snap !== 12'd0) begin n_bad++; $display("FAIL abort_outputs: got %h want 000", obs_rst_snap); end
    n_cmp++; if (obs_done_n !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", obs_done_n); end
    do_sweep(3'd1, truth(3'd1), SWEEP_LEN + 2, 1, 0, 0);
    n_cmp++; if (obs_done_cyc !== SWEEP_LEN) begin n_bad++; $display("FAIL after_abort_done: got %0d want %0d", obs_done_cyc, SWEEP_LEN); end
    n_cmp++; if (obs_result !== 4'b1110) begin n_bad++; $display("FAIL after_abort_result: got %b want 1110", obs_result); end
    n_cmp++; if (obs_pass !== 1'b1) begin n_bad++; $display("FAIL after_abort_pass: got %b want 1", obs_pass); end
  endtask

  task automatic test_back_to_back;
    do_sweep(3'd2, truth(3'd2), 2 * SWEEP_LEN + 4, SWEEP_LEN + 2, 0, 0);
    n_cmp++; if (obs_done_n !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", obs_done_n); end
    n_cmp++; if (obs_done_cyc !== SWEEP_LEN) begin n_bad++; $display("FAIL b2b_first_done: got %0d want %0d", obs_done_cyc, SWEEP_LEN); end
    n_cmp++; if (obs_done2_cyc !== 2 * SWEEP_LEN + 1) begin n_bad++; $display("FAIL b2b_second_done: got %0d want %0d", obs_done2_cyc, 2 * SWEEP_LEN + 1); end
    n_cmp++; if (obs_busy[SWEEP_LEN + 1] !== 1'b0 || obs_busy[SWEEP_LEN + 2] !== 1'b1) begin
      n_bad++; $display("FAIL b2b_restart_busy: got %b%b want 01", obs_busy[SWEEP_LEN + 1], obs_busy[SWEEP_LEN + 2]);
    end
    n_cmp++; if (obs_pass !== 1'b1) begin n_bad++; $display("FAIL b2b_pass: got %b want 1", obs_pass); end
  endtask

  task automatic test_random;
    logic [2:0] o;
    logic [3:0] t;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      t = ($urandom_range(0, 2) == 0) ? truth(o) : 4'($urandom);
      model(o, t);
      do_sweep(o, t, SWEEP_LEN + 2, 1, 0, 0);
      n_cmp++; if (obs_result !== m_result || obs_err !== 3'(m_err)) begin
        n_bad++; $display("FAIL rand_result op%0d tab%b: got %b/%0d want %b/%0d", o, t, obs_result, obs_err, m_result, m_err);
      end
      n_cmp++; if (obs_pass !== m_pass) begin n_bad++; $display("FAIL rand_pass op%0d tab%b: got %b want %b", o, t, obs_pass, m_pass); end
      n_cmp++; if (obs_done_cyc !== m_done_cyc) begin n_bad++; $display("FAIL rand_done_cycle op%0d tab%b: got %0d want %0d", o, t, obs_done_cyc, m_done_cyc); end
      n_cmp++; if (obs_xy_hold !== m_last_xy) begin n_bad++; $display("FAIL rand_xy_hold op%0d tab%b: got %b want %b", o, t, obs_xy_hold, m_last_xy); end
      n_cmp++; if (trace_dev(m_done_cyc) != 0) begin n_bad++; $display("FAIL rand_trace op%0d tab%b: got %0d bad cycles want 0", o, t, trace_dev(m_done_cyc)); end
    end
  endtask

`ifdef SWEEP_STOP_ON_FAIL_EN
  task automatic test_stop_on_fail;
    do_sweep(3'd1, 4'b0000, SWEEP_LEN + 2, 1, 0, 0);
    n_cmp++; if (obs_done_cyc !== 11) begin n_bad++; $display("FAIL stop_done_cycle: got %0d want 11", obs_done_cyc); end
    n_cmp++; if (obs_err !== 3'd1) begin n_bad++; $display("FAIL stop_err: got %0d want 1", obs_err); end
    n_cmp++; if (obs_result !== 4'b0000) begin n_bad++; $display("FAIL stop_result: got %b want 0000", obs_result); end
    n_cmp++; if (obs_xy_hold !== 2'b01) begin n_bad++; $display("FAIL stop_xy: got %b want 01", obs_xy_hold); end
    n_cmp++; if (obs_pass !== 1'b0) begin n_bad++; $display("FAIL stop_pass: got %b want 0", obs_pass); end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    test_reset();
    test_ideal_gates();
    test_stuck();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
`ifdef SWEEP_STOP_ON_FAIL_EN
    test_stop_on_fail();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking stimulus/response stage for the team's two-input logic-gate blocks (and, or, nand, nor, xor, xnor, not). On `start`, it drives `x`/`y` through all four input combinations and holds each long enough for the gate output to settle. It samples the gate's `f` for each vector, compares it against the expected truth table for the selected operation, and reports a per-vector result vector, an error count and a pass flag. It sits on both sides of a gate instance: upstream driving its inputs, downstream consuming its output.

## Interface
Parameters:
- `HOLD_CYCLES`, 4: cycles each vector is driven before `f` is sampled; legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a sweep; honoured only in IDLE.
- `op` in 3: operation under test, latched on accepted `start`.
  - 0 and, 1 or, 2 nand, 3 nor, 4 xor, 5 xnor.
  - 6 not, expected `~x`; `y` is still swept.
  - 7 buffer, expected `x`.
- `f` in 1: output of the gate under test.
- `x` out 1: gate input, equals `vec[1]`.
- `y` out 1: gate input, equals `vec[0]`.
- `busy` out 1: high in SETTLE and SAMPLE.
- `done` out 1: one-cycle pulse in DONE.
- `pass` out 1: 1 when the last sweep had `err_count == 0`.
- `result` out 4: `result[v]` = sampled `f` for vector `v`.
- `err_count` out 3: number of mismatching vectors, 0..4.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE; 2-bit vector index `vec`; 4-bit hold counter `cnt`.
- IDLE, `start`=1: latch `op`; clear `vec`, `cnt`, `result`, `err_count`, `pass` → SETTLE.
- SETTLE: drive `x`=`vec[1]`, `y`=`vec[0]`; increment `cnt`. When `cnt == HOLD_CYCLES-1` → SAMPLE.
- SAMPLE:
  - `x`/`y` stay driven.
  - `result[vec] <= f`; if `f` differs from the expected value, increment `err_count`.
  - If `vec==3` → DONE; otherwise `vec++`, `cnt<=0` → SETTLE.
- DONE:
  - `done`=1.
  - `pass <= (final err_count==0)`, including a SAMPLE-cycle mismatch on the last vector.
  - → IDLE.
- `x`, `y`, `result`, `err_count`, `pass` hold their values in IDLE until the next accepted `start`.
- `start` while not in IDLE is ignored; no queuing.
- `start` held high through DONE re-triggers on the first IDLE cycle.
- `err_count` saturates at 4 by construction; no overflow.

## Timing
- Reset (async assert, sync release): state IDLE; `x`=`y`=`busy`=`done`=`pass`=0; `result`=0; `err_count`=0.
- `rst_n` low mid-sweep aborts immediately to the reset values; no `done` pulse.
- `start` sampled at edge T → SETTLE from T+1.
- Each vector occupies `HOLD_CYCLES` SETTLE cycles + 1 SAMPLE cycle.
- `done` is high in cycle T+4·(HOLD_CYCLES+1)+1; with the default of 4, that is T+21.
- `f` is sampled at the SAMPLE edge, i.e. `HOLD_CYCLES`+1 edges after the vector was applied.
- `pass` is valid from the cycle after DONE.

## Configuration
- `SWEEP_STOP_ON_FAIL_EN` defined:
  - The first mismatch in SAMPLE goes directly to DONE.
  - `err_count`=1, `pass`=0.
  - Unvisited `result` bits stay 0.
  - `x`/`y` hold the failing vector.
- Not defined: the full four-vector sweep always runs.

## Test plan
- `op`=0, ideal AND model, HOLD_CYCLES=4, `start` at T → `x`/`y` sequence 00,01,10,11; `done` at T+21; `result`=4'b1000, `err_count`=0, `pass`=1.
- `op`=3, ideal NOR model → `result`=4'b0001, `pass`=1. Repeat `op`=5 with an ideal XNOR model → `result`=4'b1001.
- `op`=0 with `f` stuck at 1 → `result`=4'b1111, `err_count`=3, `pass`=0. Same with `f` stuck at 0 → `err_count`=1.
- `start` pulsed again at T+5 → ignored; single `done` at T+21.
- `rst_n` asserted at T+8 → all outputs 0 immediately, no `done`; a new `start` afterwards gives a full normal sweep.
- With `SWEEP_STOP_ON_FAIL_EN`, `op`=1, `f` stuck at 0 → mismatch at vec 1; `done` at T+11; `err_count`=1, `result`=4'b0000, `x`/`y`=01.
